// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, execute and writeback
// handshakes around a single instruction register, with an absorbing trap state.
module core_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] dec_instr,
  input  logic        dec_valid,
  output logic        ex_start,
  input  logic        ex_done,
  input  logic [31:0] ex_result,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] pc,
  output logic [31:0] instret,
  output logic        halted,
  output logic [31:0] trap_pc
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned RD_LSB  = 7;
  localparam int unsigned RD_W    = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_t;

  state_t            state;
  logic [XLEN-1:0]   ir;

  assign imem_addr = pc;
  assign dec_instr = ir;
  assign rf_waddr  = ir[RD_LSB +: RD_W];

  // Outputs are registered alongside the state transition that enables them,
  // so imem_req/ex_start/rf_we/halted are already valid in the state's first cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      ir       <= '0;
      rf_wdata <= '0;
      instret  <= '0;
      trap_pc  <= '0;
      imem_req <= 1'b0;
      ex_start <= 1'b0;
      rf_we    <= 1'b0;
      halted   <= 1'b0;
    end else begin
      ex_start <= 1'b0;
      rf_we    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (run) begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
          end
        end
        S_FETCH: begin
          if (imem_ready) begin
            ir       <= imem_rdata;
            state    <= S_DECODE;
            imem_req <= 1'b0;
          end
        end
        S_DECODE: begin
          if (dec_valid) begin
            state    <= S_EXECUTE;
            ex_start <= 1'b1;
          end else begin
            state    <= S_HALT;
            trap_pc  <= pc;
            halted   <= 1'b1;
          end
        end
        S_EXECUTE: begin
          if (ex_done) begin
            rf_wdata <= ex_result;
            rf_we    <= (ir[RD_LSB +: RD_W] != RD_W'(0));
            state    <= S_WRITEBACK;
          end
        end
        S_WRITEBACK: begin
          pc      <= pc + XLEN'(4);
          instret <= instret + XLEN'(1);
          // run is only sampled here and in IDLE, so a dropped run never aborts
          if (run) begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
          end else begin
            state    <= S_IDLE;
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state    <= S_IDLE;
          imem_req <= 1'b0;
          halted   <= 1'b0;
        end
      endcase
    end
  end

endmodule
